// File: rtl/misr_pkg.sv
// Shared MISR definitions: FSM state encoding, default feedback polynomial and
// the signature update equation used by both the RTL and its reference model.
package misr_pkg;

    localparam int unsigned MISR_MAXW     = 64;
    localparam logic [7:0]  MISR_DEF_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } misr_state_t;

    // Width-generic form: operands are zero-extended to MISR_MAXW and the result is
    // masked back to w bits, so any WIDTH up to MISR_MAXW shares one equation.
    function automatic logic [MISR_MAXW-1:0] misr_next(
        input logic [MISR_MAXW-1:0] sig,
        input logic [MISR_MAXW-1:0] din,
        input logic [MISR_MAXW-1:0] poly,
        input int unsigned          w
    );
        logic [MISR_MAXW-1:0] mask;
        logic [MISR_MAXW-1:0] fb;
        mask = (w >= MISR_MAXW) ? '1 : ((64'd1 << w) - 64'd1);
        fb   = (|(sig & (64'd1 << (w - 1)))) ? poly : '0;
        return ((sig << 1) ^ fb ^ din) & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: synchronous seed load, per-word update when enabled.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= WIDTH'(misr_next(MISR_MAXW'(sig), MISR_MAXW'(din), MISR_MAXW'(POLY), WIDTH));
        end
    end

endmodule

// File: rtl/resp_misr.sv
// Response MISR: compacts n_pat response words and checks against a golden signature.
// Build option RESP_MISR_XMASK_EN adds resp_mask to zero don't-care bits before compaction.
module resp_misr
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_pat,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
`ifdef RESP_MISR_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pat_cnt
);

    misr_state_t      state_q, state_d;
    logic [CNT_W-1:0] n_pat_q;
    logic [WIDTH-1:0] golden_q;
    logic [WIDTH-1:0] din;
    logic             start_ok;
    logic             accept;
    logic             last;

`ifdef RESP_MISR_XMASK_EN
    assign din = resp & ~resp_mask;
`else
    assign din = resp;
`endif

    assign start_ok = start && (state_q == IDLE);
    assign accept   = resp_valid && resp_ready;
    assign last     = accept && ((pat_cnt + CNT_W'(1)) == n_pat_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (n_pat == '0) ? COMPARE : CAPTURE;
            CAPTURE: if (last) state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_ready = (state_q == CAPTURE);
        busy       = (state_q == CAPTURE) || (state_q == COMPARE);
        done       = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt  <= '0;
            n_pat_q  <= '0;
            golden_q <= '0;
            pass     <= 1'b0;
        end else begin
            if (start_ok) begin
                pat_cnt  <= '0;
                n_pat_q  <= n_pat;
                golden_q <= golden;
                pass     <= 1'b0;
            end else if (accept) begin
                pat_cnt <= pat_cnt + CNT_W'(1);
            end
            if (state_q == COMPARE) begin
                pass <= (signature == golden_q);
            end
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .en    (accept),
        .din   (din),
        .sig   (signature)
    );

endmodule
